// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared forward-select encodings and shadow-stage types
package cpu_pkg;

  localparam int REG_W = 5;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  typedef struct packed {
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [REG_W-1:0] rd;
    logic             regwrite;
    logic             memread;
  } ex_shadow_t;

  typedef struct packed {
    logic [REG_W-1:0] rd;
    logic             regwrite;
  } dst_shadow_t;

endpackage

// File: rtl/fwd_select.sv
// rtl/fwd_select.sv - priority compare choosing one EX operand source
module fwd_select #(
  parameter int W = 5
) (
  input  logic [W-1:0] src_i,
  input  logic [W-1:0] mem_rd_i,
  input  logic         mem_regwrite_i,
  input  logic [W-1:0] wb_rd_i,
  input  logic         wb_regwrite_i,
  output logic [1:0]   sel_o
);
  import cpu_pkg::*;

  logic hit_mem;
  logic hit_wb;

  // x0 is hardwired zero, so a write to it must never be forwarded
  assign hit_mem = mem_regwrite_i && (mem_rd_i != '0) && (mem_rd_i == src_i);
  assign hit_wb  = wb_regwrite_i  && (wb_rd_i  != '0) && (wb_rd_i  == src_i);

  always_comb begin
    sel_o = FWD_RF;
    if (hit_mem) begin
      sel_o = FWD_EXMEM;
    end else if (hit_wb) begin
      sel_o = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// rtl/fwd_hazard_ctrl.sv - operand forwarding, load-use bubbles and miss freeze
module fwd_hazard_ctrl #(
  parameter int REG_W = cpu_pkg::REG_W,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [REG_W-1:0] id_rs1_i,
  input  logic [REG_W-1:0] id_rs2_i,
  input  logic [REG_W-1:0] id_rd_i,
  input  logic             id_regwrite_i,
  input  logic             id_memread_i,
  input  logic             mem_stall_i,
  output logic [1:0]       fwd_a_o,
  output logic [1:0]       fwd_b_o,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             idex_bubble_o,
  output logic             pipe_hold_o,
  output logic [CNT_W-1:0] stall_cnt_o
);
  import cpu_pkg::*;

  ex_shadow_t       ex_q,  ex_d;
  dst_shadow_t      mem_q, mem_d;
  dst_shadow_t      wb_q,  wb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lu;

  // Sources are checked even when the ID instruction does not write (stores, branches)
  assign lu = ex_q.memread && ex_q.regwrite && (ex_q.rd != '0) &&
              ((ex_q.rd == id_rs1_i) || (ex_q.rd == id_rs2_i));

  always_comb begin
    ex_d  = ex_q;
    mem_d = mem_q;
    wb_d  = wb_q;
    cnt_d = cnt_q;
    if (!mem_stall_i) begin
      wb_d           = mem_q;
      mem_d.rd       = ex_q.rd;
      mem_d.regwrite = ex_q.regwrite;
      if (lu) begin
        ex_d = '0;
      end else begin
        ex_d.rs1      = id_rs1_i;
        ex_d.rs2      = id_rs2_i;
        ex_d.rd       = id_rd_i;
        ex_d.regwrite = id_regwrite_i;
        ex_d.memread  = id_memread_i;
      end
    end
    if ((mem_stall_i || lu) && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
      cnt_q <= cnt_d;
    end
  end

  fwd_select #(.W(REG_W)) u_fwd_a (
    .src_i          (ex_q.rs1),
    .mem_rd_i       (mem_q.rd),
    .mem_regwrite_i (mem_q.regwrite),
    .wb_rd_i        (wb_q.rd),
    .wb_regwrite_i  (wb_q.regwrite),
    .sel_o          (fwd_a_o)
  );

  fwd_select #(.W(REG_W)) u_fwd_b (
    .src_i          (ex_q.rs2),
    .mem_rd_i       (mem_q.rd),
    .mem_regwrite_i (mem_q.regwrite),
    .wb_rd_i        (wb_q.rd),
    .wb_regwrite_i  (wb_q.regwrite),
    .sel_o          (fwd_b_o)
  );

  assign pipe_hold_o   = mem_stall_i;
  assign pc_write_o    = ~(mem_stall_i | lu);
  assign ifid_write_o  = ~(mem_stall_i | lu);
  assign idex_bubble_o = lu & ~mem_stall_i;
  assign stall_cnt_o   = cnt_q;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// tb/tb_fwd_hazard_ctrl.sv - directed-vector bench for fwd_hazard_ctrl
module tb_fwd_hazard_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [4:0]  id_rs1_i, id_rs2_i, id_rd_i;
  logic        id_regwrite_i, id_memread_i, mem_stall_i;
  logic [1:0]  fwd_a_o, fwd_b_o;
  logic        pc_write_o, ifid_write_o, idex_bubble_o, pipe_hold_o;
  logic [15:0] stall_cnt_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_i = ~clk_i;

  fwd_hazard_ctrl #(.REG_W(5), .CNT_W(16)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .id_rs1_i      (id_rs1_i),
    .id_rs2_i      (id_rs2_i),
    .id_rd_i       (id_rd_i),
    .id_regwrite_i (id_regwrite_i),
    .id_memread_i  (id_memread_i),
    .mem_stall_i   (mem_stall_i),
    .fwd_a_o       (fwd_a_o),
    .fwd_b_o       (fwd_b_o),
    .pc_write_o    (pc_write_o),
    .ifid_write_o  (ifid_write_o),
    .idex_bubble_o (idex_bubble_o),
    .pipe_hold_o   (pipe_hold_o),
    .stall_cnt_o   (stall_cnt_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic id_in(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic rw, input logic mr);
    id_rs1_i      = rs1;
    id_rs2_i      = rs2;
    id_rd_i       = rd;
    id_regwrite_i = rw;
    id_memread_i  = mr;
  endtask

  task automatic do_reset();
    rst_i       = 1'b1;
    mem_stall_i = 1'b0;
    id_in(0, 0, 0, 0, 0);
    tick();
    rst_i = 1'b0;
  endtask

  initial begin
    rst_i       = 1'b1;
    mem_stall_i = 1'b0;
    id_in(0, 0, 0, 0, 0);
    #3;
    check("rst_fwd_a",  fwd_a_o, 2'b00);
    check("rst_fwd_b",  fwd_b_o, 2'b00);
    check("rst_cnt",    stall_cnt_o, 0);
    check("rst_pcw",    pc_write_o, 1);
    check("rst_ifidw",  ifid_write_o, 1);
    check("rst_bubble", idex_bubble_o, 0);
    check("rst_hold",   pipe_hold_o, 0);
    rst_i = 1'b0;

    // add x5 then sub x6,x5,x7
    tick(); id_in(1, 2, 5, 1, 0);
    tick(); id_in(5, 7, 6, 1, 0);
    #1; check("alu_no_stall", pc_write_o, 1);
    tick(); #1;
    check("alu_fwd_a", fwd_a_o, 2'b10);
    check("alu_fwd_b", fwd_b_o, 2'b00);

    // add x5, filler x9, reader with rs2 = x5
    id_in(1, 2, 5, 1, 0); tick();
    id_in(0, 0, 9, 1, 0); tick();
    id_in(3, 5, 10, 1, 0); tick(); #1;
    check("wb_fwd_a", fwd_a_o, 2'b00);
    check("wb_fwd_b", fwd_b_o, 2'b01);

    // x5 written twice in a row: EX/MEM wins
    id_in(1, 2, 5, 1, 0); tick();
    id_in(3, 4, 5, 1, 0); tick();
    id_in(11, 5, 13, 1, 0); tick(); #1;
    check("both_fwd_a", fwd_a_o, 2'b00);
    check("both_fwd_b", fwd_b_o, 2'b10);

    // load into x0 followed by reader of x0
    id_in(1, 0, 0, 1, 1); tick();
    id_in(0, 0, 14, 1, 0); #1;
    check("x0_no_stall", pc_write_o, 1);
    check("x0_no_bubble", idex_bubble_o, 0);
    tick(); #1;
    check("x0_fwd_a", fwd_a_o, 2'b00);
    check("x0_fwd_b", fwd_b_o, 2'b00);

    // lw x4 then add x8,x4,x4
    id_in(1, 0, 4, 1, 1); tick();
    id_in(4, 4, 8, 1, 0); #1;
    check("lu_pcw",    pc_write_o, 0);
    check("lu_ifidw",  ifid_write_o, 0);
    check("lu_bubble", idex_bubble_o, 1);
    check("lu_hold",   pipe_hold_o, 0);
    check("lu_cnt0",   stall_cnt_o, 0);
    tick(); #1;
    check("lu_after_pcw",    pc_write_o, 1);
    check("lu_after_bubble", idex_bubble_o, 0);
    check("lu_cnt1",         stall_cnt_o, 1);
    tick(); #1;
    check("lu_fwd_a", fwd_a_o, 2'b01);
    check("lu_fwd_b", fwd_b_o, 2'b01);
    check("lu_cnt1b", stall_cnt_o, 1);

    // 5-cycle cache miss over a load-use pair
    do_reset();
    id_in(1, 0, 4, 1, 1); tick();
    id_in(4, 6, 12, 1, 0);
    mem_stall_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("miss_hold",   pipe_hold_o, 1);
      check("miss_bubble", idex_bubble_o, 0);
      check("miss_pcw",    pc_write_o, 0);
      check("miss_cnt",    stall_cnt_o, i);
      tick();
    end
    mem_stall_i = 1'b0; #1;
    check("miss_end_bubble", idex_bubble_o, 1);
    check("miss_end_hold",   pipe_hold_o, 0);
    check("miss_end_cnt",    stall_cnt_o, 5);
    tick(); #1;
    check("miss_cnt6",       stall_cnt_o, 6);
    check("miss_post_bubble", idex_bubble_o, 0);
    check("miss_post_pcw",   pc_write_o, 1);
    tick(); #1;
    check("miss_fwd_a", fwd_a_o, 2'b01);
    check("miss_fwd_b", fwd_b_o, 2'b00);

    // async reset in the bubble cycle
    id_in(12, 0, 4, 1, 1); tick();
    id_in(4, 4, 8, 1, 0); #1;
    check("ar_pre_bubble", idex_bubble_o, 1);
    check("ar_pre_fwd_a",  fwd_a_o, 2'b10);
    rst_i = 1'b1; #1;
    check("ar_bubble", idex_bubble_o, 0);
    check("ar_pcw",    pc_write_o, 1);
    check("ar_ifidw",  ifid_write_o, 1);
    check("ar_fwd_a",  fwd_a_o, 2'b00);
    check("ar_fwd_b",  fwd_b_o, 2'b00);
    check("ar_cnt",    stall_cnt_o, 0);
    check("ar_hold",   pipe_hold_o, 0);
    tick();
    rst_i = 1'b0;
    id_in(0, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
